// File: rtl/static_buff_sched_pkg.sv
// Shared sizing and types for the static buffer scheduler and its clients.
package static_buff_pkg;
  localparam int NUMELEM   = 4;
  localparam int BITDATA   = 4;
  localparam int NUMFIFO   = 8;
  localparam int DAT_DELAY = 1;
  localparam int QPT_DELAY = 1;
  localparam int CREDITS   = 4;

  localparam int BITFIFO   = (NUMFIFO > 1) ? $clog2(NUMFIFO) : 1;
  localparam int BITELEM   = $clog2(NUMELEM);
  localparam int POP_DELAY = DAT_DELAY + QPT_DELAY;
  localparam int BITCRED   = $clog2(CREDITS + 1);

  typedef logic [BITFIFO-1:0] fifo_idx_t;
  // One extra bit so a completely full queue (cnt == NUMELEM) is representable.
  typedef logic [BITELEM:0]   cnt_t;
  typedef logic [BITCRED-1:0] cred_t;
endpackage

// File: rtl/static_buff_sched_rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer, wrapping N-1 -> 0.
module rr_arb #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic         gnt_vld,
  output logic [N-1:0] gnt_oh,
  output logic [W-1:0] gnt_bin
);
  logic [W-1:0] ptr;
  logic [W-1:0] idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_bin = '0;
    gnt_oh  = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = W'((int'(ptr) + i) % N);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_bin = idx;
      end
    end
    if (gnt_vld) gnt_oh[gnt_bin] = 1'b1;
  end

  // The pointer only moves on a grant, so idle cycles keep fairness intact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (gnt_bin == W'(N - 1)) ? '0 : gnt_bin + 1'b1;
    end
  end
endmodule

// File: rtl/static_buff_sched.sv
// Front-end for the multi-queue static buffer: guarded pushes, credit-limited
// round-robin pops, and a tag pipeline that realigns pop data with its queue.
module static_buff_sched
  import static_buff_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               buf_ready,
  input  logic               in_vld,
  input  logic [BITFIFO-1:0] in_prt,
  input  logic [BITDATA-1:0] in_din,
  output logic               in_rdy,
  input  logic [NUMFIFO-1:0] q_en,
  output logic               buf_push,
  output logic [BITFIFO-1:0] buf_pu_prt,
  output logic [BITDATA-1:0] buf_pu_din,
  output logic               buf_pop,
  output logic [BITFIFO-1:0] buf_po_prt,
  input  logic [BITDATA-1:0] buf_po_dout,
  input  logic               cr_ret,
  output logic               out_vld,
  output logic [BITFIFO-1:0] out_prt,
  output logic [BITDATA-1:0] out_dout,
  output logic [NUMFIFO-1:0] q_empty,
  output logic [NUMFIFO-1:0] q_full
);
  cnt_t               cnt [NUMFIFO];
  cred_t              credit;
  logic [NUMFIFO-1:0] cand;
  logic [NUMFIFO-1:0] push_oh;
  logic [NUMFIFO-1:0] pop_oh;
  logic               gnt_vld;
  fifo_idx_t          gnt_bin;
  logic [POP_DELAY-1:0] vld_sr;
  fifo_idx_t          prt_sr [POP_DELAY];

  always_comb begin
    q_empty = '0;
    q_full  = '0;
    for (int q = 0; q < NUMFIFO; q++) begin
      q_empty[q] = (cnt[q] == '0);
      q_full[q]  = (cnt[q] == cnt_t'(NUMELEM));
    end
  end

  // Handshake: an upstream write transfers on a cycle with in_vld && in_rdy;
  // in_rdy never looks at in_vld or at a same-cycle pop of the target queue.
  always_comb begin
    in_rdy     = buf_ready && !q_full[in_prt];
    buf_push   = in_vld && in_rdy;
    buf_pu_prt = buf_push ? in_prt : '0;
    buf_pu_din = buf_push ? in_din : '0;
    push_oh    = buf_push ? ({{(NUMFIFO-1){1'b0}}, 1'b1} << in_prt) : '0;
  end

  always_comb begin
    cand = '0;
    for (int q = 0; q < NUMFIFO; q++) begin
      cand[q] = q_en[q] && !q_empty[q] && (credit != '0) && buf_ready;
    end
  end

  rr_arb #(
    .N (NUMFIFO),
    .W (BITFIFO)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (cand),
    .gnt_vld (gnt_vld),
    .gnt_oh  (pop_oh),
    .gnt_bin (gnt_bin)
  );

  assign buf_pop    = gnt_vld;
  assign buf_po_prt = gnt_bin;

  // Counts are updated at issue time, ahead of the buffer's own bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int q = 0; q < NUMFIFO; q++) cnt[q] <= '0;
    end else begin
      for (int q = 0; q < NUMFIFO; q++) begin
        case ({push_oh[q], pop_oh[q]})
          2'b10:   cnt[q] <= cnt[q] + 1'b1;
          2'b01:   cnt[q] <= cnt[q] - 1'b1;
          default: cnt[q] <= cnt[q];
        endcase
      end
    end
  end

  // A return while already at CREDITS is a downstream protocol error; saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit <= cred_t'(CREDITS);
    end else begin
      case ({buf_pop, cr_ret})
        2'b10:   credit <= credit - 1'b1;
        2'b01:   if (credit != cred_t'(CREDITS)) credit <= credit + 1'b1;
        default: credit <= credit;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_sr <= '0;
      for (int i = 0; i < POP_DELAY; i++) prt_sr[i] <= '0;
    end else begin
      vld_sr[0] <= buf_pop;
      prt_sr[0] <= buf_po_prt;
      for (int i = 1; i < POP_DELAY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        prt_sr[i] <= prt_sr[i-1];
      end
    end
  end

  assign out_vld  = vld_sr[POP_DELAY-1];
  assign out_prt  = prt_sr[POP_DELAY-1];
  assign out_dout = buf_po_dout;
endmodule

// File: tb/tb_static_buff_sched.sv
// Bench for static_buff_sched with a behavioural 2-cycle-latency buffer model.
module tb_static_buff_sched;
  logic       clk = 1'b0;
  logic       rst;
  logic       buf_ready;
  logic       in_vld;
  logic [2:0] in_prt;
  logic [3:0] in_din;
  logic       in_rdy;
  logic [7:0] q_en;
  logic       buf_push;
  logic [2:0] buf_pu_prt;
  logic [3:0] buf_pu_din;
  logic       buf_pop;
  logic [2:0] buf_po_prt;
  logic [3:0] buf_po_dout;
  logic       cr_ret;
  logic       out_vld;
  logic [2:0] out_prt;
  logic [3:0] out_dout;
  logic [7:0] q_empty;
  logic [7:0] q_full;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int pop_count = 0;
  logic [6:0] exp_q[$];
  int pop_cyc[$];

  static_buff_sched dut (
    .clk         (clk),
    .rst         (rst),
    .buf_ready   (buf_ready),
    .in_vld      (in_vld),
    .in_prt      (in_prt),
    .in_din      (in_din),
    .in_rdy      (in_rdy),
    .q_en        (q_en),
    .buf_push    (buf_push),
    .buf_pu_prt  (buf_pu_prt),
    .buf_pu_din  (buf_pu_din),
    .buf_pop     (buf_pop),
    .buf_po_prt  (buf_po_prt),
    .buf_po_dout (buf_po_dout),
    .cr_ret      (cr_ret),
    .out_vld     (out_vld),
    .out_prt     (out_prt),
    .out_dout    (out_dout),
    .q_empty     (q_empty),
    .q_full      (q_full)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // buffer model: pop data appears two cycles after the pop
  logic [3:0] bmem [8][4];
  logic [1:0] bhead [8];
  logic [1:0] btail [8];
  int         bcnt [8];
  logic [3:0] bs1, bs2;
  assign buf_po_dout = bs2;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int q = 0; q < 8; q++) begin
        bhead[q] <= '0;
        btail[q] <= '0;
        bcnt[q]  <= 0;
      end
      bs1 <= '0;
      bs2 <= '0;
    end else begin
      if (buf_push) begin
        n_vec++;
        if (bcnt[buf_pu_prt] >= 4) begin
          n_err++;
          $display("FAIL buf_overfill: q%0d count %0d required below 4", buf_pu_prt, bcnt[buf_pu_prt]);
        end
        bmem[buf_pu_prt][btail[buf_pu_prt]] <= buf_pu_din;
        btail[buf_pu_prt] <= btail[buf_pu_prt] + 2'd1;
      end
      if (buf_pop) begin
        n_vec++;
        if (bcnt[buf_po_prt] == 0) begin
          n_err++;
          $display("FAIL buf_underflow: q%0d count 0 required above 0", buf_po_prt);
        end
        bs1 <= bmem[buf_po_prt][bhead[buf_po_prt]];
        bhead[buf_po_prt] <= bhead[buf_po_prt] + 2'd1;
      end
      bs2 <= bs1;
      for (int q = 0; q < 8; q++) begin
        bcnt[q] <= bcnt[q] + ((buf_push && buf_pu_prt == 3'(q)) ? 1 : 0)
                           - ((buf_pop && buf_po_prt == 3'(q)) ? 1 : 0);
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [6:0] e;
    int pc;
    if (!rst) begin
      pop_cyc.delete();
    end else begin
      if (buf_pop) begin
        pop_cyc.push_back(cyc);
        pop_count++;
      end
      if (out_vld) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_unexpected: got prt %0d data %0h, nothing expected", out_prt, out_dout);
        end else begin
          e = exp_q.pop_front();
          if ({out_prt, out_dout} !== e) begin
            n_err++;
            $display("FAIL out_data: got prt %0d data %0h, required prt %0d data %0h",
                     out_prt, out_dout, e[6:4], e[3:0]);
          end
        end
        if (pop_cyc.size() > 0) begin
          pc = pop_cyc.pop_front();
          n_vec++;
          if (cyc - pc != 2) begin
            n_err++;
            $display("FAIL out_latency: got %0d cycles, required 2", cyc - pc);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [2:0] p, input logic [3:0] d);
    in_vld = 1'b1;
    in_prt = p;
    in_din = d;
    #1;
    check("push_rdy", in_rdy, 1);
    tick();
    in_vld = 1'b0;
  endtask

  task automatic ret_credit(input int n);
    repeat (n) begin
      cr_ret = 1'b1;
      tick();
    end
    cr_ret = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      tick();
      t++;
    end
    check("drain", exp_q.size(), 0);
    tick(2);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    buf_ready = 1'b0;
    in_vld = 1'b0;
    in_prt = '0;
    in_din = '0;
    q_en = '0;
    cr_ret = 1'b0;
    tick(3);
    check("rst_in_rdy", in_rdy, 0);
    check("rst_buf_pop", buf_pop, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_q_empty", q_empty, 8'hFF);
    check("rst_q_full", q_full, 8'h00);
    rst = 1'b1;
    tick();
    buf_ready = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    apply_reset();
    check("rst_buf_push", buf_push, 0);
    check("rst_out_prt", out_prt, 0);

    // 1: two words into q3, drained in order
    p0 = pop_count;
    push(3'd3, 4'hA);
    push(3'd3, 4'hB);
    check("t1_q_empty", q_empty, 8'hF7);
    exp_q.push_back({3'd3, 4'hA});
    exp_q.push_back({3'd3, 4'hB});
    q_en = 8'hFF;
    wait_drain();
    check("t1_pops", pop_count - p0, 2);
    check("t1_empty_after", q_empty, 8'hFF);
    q_en = 8'h00;
    ret_credit(2);

    // 2: fill q1, push refused only for the full queue
    p0 = pop_count;
    for (int i = 1; i <= 4; i++) push(3'd1, 4'(i));
    check("t2_q_full", q_full, 8'h02);
    in_vld = 1'b1;
    in_prt = 3'd1;
    in_din = 4'h5;
    #1;
    check("t2_rdy_full", in_rdy, 0);
    check("t2_push_full", buf_push, 0);
    in_prt = 3'd2;
    #1;
    check("t2_rdy_other", in_rdy, 1);
    in_vld = 1'b0;
    for (int i = 1; i <= 4; i++) exp_q.push_back({3'd1, 4'(i)});
    q_en = 8'h02;
    wait_drain();
    check("t2_pops", pop_count - p0, 4);
    q_en = 8'h00;
    ret_credit(4);

    // 3: round-robin order 0,2,7 then wrap back to 0
    apply_reset();
    push(3'd0, 4'h5);
    push(3'd2, 4'h6);
    push(3'd7, 4'h7);
    exp_q.push_back({3'd0, 4'h5});
    exp_q.push_back({3'd2, 4'h6});
    exp_q.push_back({3'd7, 4'h7});
    q_en = 8'hFF;
    #1;
    check("t3_first_pop", buf_pop, 1);
    check("t3_first_prt", buf_po_prt, 0);
    wait_drain();
    exp_q.push_back({3'd0, 4'h8});
    push(3'd0, 4'h8);
    wait_drain();
    q_en = 8'h00;
    ret_credit(4);

    // 4: credit limit of 4, one returned credit allows exactly one pop
    p0 = pop_count;
    for (int i = 0; i < 6; i++) push(3'(i), 4'(i + 1));
    exp_q.push_back({3'd1, 4'h2});
    exp_q.push_back({3'd2, 4'h3});
    exp_q.push_back({3'd3, 4'h4});
    exp_q.push_back({3'd4, 4'h5});
    exp_q.push_back({3'd5, 4'h6});
    exp_q.push_back({3'd0, 4'h1});
    q_en = 8'hFF;
    tick(8);
    check("t4_pops_cap", pop_count - p0, 4);
    check("t4_pop_idle", buf_pop, 0);
    ret_credit(1);
    tick(4);
    check("t4_pops_one_more", pop_count - p0, 5);
    check("t4_pop_idle2", buf_pop, 0);
    ret_credit(5);
    wait_drain();
    check("t4_pops_total", pop_count - p0, 6);
    q_en = 8'h00;

    // 5: push and pop q5 in the same cycle
    push(3'd5, 4'hC);
    exp_q.push_back({3'd5, 4'hC});
    exp_q.push_back({3'd5, 4'hD});
    q_en = 8'h20;
    in_vld = 1'b1;
    in_prt = 3'd5;
    in_din = 4'hD;
    #1;
    check("t5_pop", buf_pop, 1);
    check("t5_pop_prt", buf_po_prt, 5);
    check("t5_push", buf_push, 1);
    tick();
    in_vld = 1'b0;
    q_en = 8'h00;
    #1;
    check("t5_cnt_one", q_empty, 8'hDF);
    check("t5_not_full", q_full, 8'h00);
    q_en = 8'h20;
    wait_drain();
    q_en = 8'h00;
    ret_credit(2);
    check("t5_empty_after", q_empty, 8'hFF);

    // 6: reset with two pops in flight
    push(3'd2, 4'h1);
    push(3'd6, 4'h2);
    q_en = 8'hFF;
    tick(2);
    rst = 1'b0;
    buf_ready = 1'b0;
    q_en = 8'h00;
    #1;
    check("t6_vld_in_rst", out_vld, 0);
    tick(2);
    rst = 1'b1;
    tick();
    buf_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t6_vld_after_rst", out_vld, 0);
      tick();
    end
    check("t6_q_empty", q_empty, 8'hFF);
    p0 = pop_count;
    for (int i = 0; i < 5; i++) push(3'(i), 4'(i + 1));
    for (int i = 0; i < 5; i++) exp_q.push_back({3'(i), 4'(i + 1)});
    q_en = 8'hFF;
    tick(8);
    check("t6_credit_four", pop_count - p0, 4);
    ret_credit(1);
    wait_drain();
    check("t6_pops_total", pop_count - p0, 5);
    q_en = 8'h00;
    ret_credit(4);

    tick(4);
    check("final_exp_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
